// File: rtl/backdoor_spi_pkg.sv
// Shared definitions for the backdoor SPI slave: FSM state encoding,
// command field layout and a small elaboration-time helper.
package backdoor_spi_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        ADDR    = 3'd2,
        WDATA   = 3'd3,
        RD_WAIT = 3'd4,
        TDATA   = 3'd5,
        DONE    = 3'd6
    } state_e;

    localparam int CMD_WIDTH  = 8;
    localparam int CMD_RW_BIT = 7;

    // Largest of three widths; sizes the RX shifter and the bit counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/backdoor_spi_shift_reg.sv
// Parameterised MSB-first shift register with parallel load.
// Load has priority over shift; bits enter at the LSB end.
module backdoor_spi_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             shift_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] data_o,
    output logic             msb_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next-state: parallel load wins over a shift in the same cycle.
    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = load_data_i;
        end else if (shift_i) begin
            data_d = {data_q[WIDTH-2:0], bit_i};
        end
    end

    // Register with synchronous active-low clear.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;
    assign msb_o  = data_q[WIDTH-1];

endmodule

// File: rtl/backdoor_spi_slave_core.sv
// SPI mode-0 slave frame engine. Decodes edges from pre-synchronised
// SCK/CS_N/MOSI sample pairs, deserialises command/address/write data,
// issues single-cycle register strobes and shifts read data out on MISO.
module backdoor_spi_slave_core
    import backdoor_spi_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_CLK,
    input  logic                  i_RST_N,
    input  logic [1:0]            i_SCK_Q,
    input  logic [1:0]            i_CS_Q,
    input  logic [1:0]            i_MOSI_Q,
    input  logic [DATA_WIDTH-1:0] i_RDATA,
    output logic                  o_MISO,
    output logic                  o_MISO_OE,
    output logic                  o_WR_EN,
    output logic                  o_RD_EN,
    output logic [ADDR_WIDTH-1:0] o_ADDR,
    output logic [DATA_WIDTH-1:0] o_WDATA,
    output logic                  o_BUSY
);

    localparam int RX_WIDTH  = max3(CMD_WIDTH, ADDR_WIDTH, DATA_WIDTH);
    localparam int CNT_WIDTH = $clog2(RX_WIDTH + 1);

    localparam logic [CNT_WIDTH-1:0] CMD_LAST  = CNT_WIDTH'(CMD_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] ADDR_LAST = CNT_WIDTH'(ADDR_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] DATA_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

    // Edge decode on the {older, newer} sample pairs.
    logic sck_rise;
    logic sck_fall;
    logic cs_start;
    logic cs_end;
    logic mosi_bit;

    assign sck_rise = (i_SCK_Q == 2'b01);
    assign sck_fall = (i_SCK_Q == 2'b10);
    assign cs_start = (i_CS_Q == 2'b10);
    assign cs_end   = (i_CS_Q == 2'b01);
    assign mosi_bit = i_MOSI_Q[1];

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   rw_q, rw_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic                   wr_en_q, wr_en_d;
    logic                   rd_en_q, rd_en_d;
    logic                   rd_dly_q;
    logic                   miso_oe_q, miso_oe_d;

    // Shifter control.
    logic                   rx_clear;
    logic                   rx_shift;
    logic [RX_WIDTH-1:0]    rx_data;
    logic                   rx_msb;
    logic [RX_WIDTH-1:0]    rx_next;
    logic                   tx_load;
    logic [DATA_WIDTH-1:0]  tx_load_data;
    logic                   tx_shift;
    logic [DATA_WIDTH-1:0]  tx_data;
    logic                   tx_msb;

    // Field values are captured on the same cycle as the final bit is
    // shifted, so look at what the RX register is about to hold.
    assign rx_next = {rx_data[RX_WIDTH-2:0], mosi_bit};

    backdoor_spi_shift_reg #(
        .WIDTH (RX_WIDTH)
    ) u_rx (
        .clk_i       (i_CLK),
        .rst_ni      (i_RST_N),
        .load_i      (rx_clear),
        .load_data_i ('0),
        .shift_i     (rx_shift),
        .bit_i       (mosi_bit),
        .data_o      (rx_data),
        .msb_o       (rx_msb)
    );

    backdoor_spi_shift_reg #(
        .WIDTH (DATA_WIDTH)
    ) u_tx (
        .clk_i       (i_CLK),
        .rst_ni      (i_RST_N),
        .load_i      (tx_load),
        .load_data_i (tx_load_data),
        .shift_i     (tx_shift),
        .bit_i       (1'b0),
        .data_o      (tx_data),
        .msb_o       (tx_msb)
    );

    // Next-state, field capture and strobe generation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_WIDTH'(1);
        rw_d         = rw_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wr_en_d      = 1'b0;
        rd_en_d      = 1'b0;
        miso_oe_d    = miso_oe_q;
        rx_clear     = 1'b0;
        rx_shift     = 1'b0;
        tx_load      = 1'b0;
        tx_load_data = i_RDATA;
        tx_shift     = 1'b0;

        if (cs_end && (state_q inside {CMD, ADDR, WDATA, RD_WAIT, TDATA})) begin
            // Aborted frame: drop everything except the last completed address.
            state_d      = IDLE;
            miso_oe_d    = 1'b0;
            tx_load      = 1'b1;
            tx_load_data = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs_start) begin
                        state_d  = CMD;
                        rx_clear = 1'b1;
                    end
                end
                CMD: begin
                    if (sck_rise) begin
                        rx_shift = 1'b1;
                        if (cnt_q == CMD_LAST) begin
                            rw_d    = rx_next[CMD_RW_BIT];
                            state_d = ADDR;
                        end
                    end
                end
                ADDR: begin
                    if (sck_rise) begin
                        rx_shift = 1'b1;
                        if (cnt_q == ADDR_LAST) begin
                            addr_d = rx_next[ADDR_WIDTH-1:0];
                            if (rw_q) begin
                                state_d = WDATA;
                            end else begin
                                state_d = RD_WAIT;
                                rd_en_d = 1'b1;
                            end
                        end
                    end
                end
                WDATA: begin
                    if (sck_rise) begin
                        rx_shift = 1'b1;
                        if (cnt_q == DATA_LAST) begin
                            wdata_d = rx_next[DATA_WIDTH-1:0];
                            wr_en_d = 1'b1;
                            state_d = DONE;
                        end
                    end
                end
                RD_WAIT: begin
                    // Read data arrives the cycle after the strobe; the first
                    // fall is only honoured once the MSB is already on MISO.
                    if (rd_dly_q) begin
                        tx_load   = 1'b1;
                        miso_oe_d = 1'b1;
                    end else if (sck_fall && miso_oe_q) begin
                        state_d = TDATA;
                    end
                end
                TDATA: begin
                    if (sck_fall) begin
                        tx_shift = 1'b1;
                    end
                    if (sck_rise && (cnt_q == DATA_LAST)) begin
                        state_d   = DONE;
                        miso_oe_d = 1'b0;
                    end else if (!sck_rise) begin
                        cnt_d = cnt_q;
                    end
                end
                DONE: begin
                    if (cs_end) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Counter only advances on shifting edges and restarts per state.
        if ((state_q inside {CMD, ADDR, WDATA}) && !sck_rise) begin
            cnt_d = cnt_q;
        end
        if (!(state_q inside {CMD, ADDR, WDATA, TDATA})) begin
            cnt_d = cnt_q;
        end
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_dly_q  <= 1'b0;
            miso_oe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            rd_dly_q  <= rd_en_q;
            miso_oe_q <= miso_oe_d;
        end
    end

    assign o_MISO    = miso_oe_q & tx_msb;
    assign o_MISO_OE = miso_oe_q;
    assign o_WR_EN   = wr_en_q;
    assign o_RD_EN   = rd_en_q;
    assign o_ADDR    = addr_q;
    assign o_WDATA   = wdata_q;
    assign o_BUSY    = (state_q != IDLE);

    // Bits that exist for symmetry of the shifter/synchroniser interfaces.
    logic unused_bits;
    assign unused_bits = ^{i_MOSI_Q[0], rx_msb, rx_next, tx_data};

endmodule

// File: tb/tb_backdoor_spi_slave_core.sv
// Bench for backdoor_spi_slave_core: drives raw SPI pins through a local
// two-flop synchroniser model, scoreboards register strobes and MISO data.
module tb_backdoor_spi_slave_core;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int HP     = 4;
    localparam logic [31:0] GARBAGE = 32'hBAD0_BAD0;

    typedef struct {
        logic        is_wr;
        logic [7:0]  addr;
        logic [31:0] data;
    } sb_item_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sck_raw, cs_raw, mosi_raw;
    logic [1:0]  sck_q  = 2'b00;
    logic [1:0]  cs_q   = 2'b11;
    logic [1:0]  mosi_q = 2'b00;
    logic [31:0] rdata;

    logic        o_MISO, o_MISO_OE, o_WR_EN, o_RD_EN, o_BUSY;
    logic [7:0]  o_ADDR;
    logic [31:0] o_WDATA;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_rise = 0;
    int wr_count = 0;
    int rd_count = 0;

    sb_item_t    sb_q[$];
    logic [31:0] miso_q[$];
    sb_item_t    mon_e;

    backdoor_spi_slave_core #(
        .ADDR_WIDTH (ADDR_W),
        .DATA_WIDTH (DATA_W)
    ) dut (
        .i_CLK     (clk),
        .i_RST_N   (rst_n),
        .i_SCK_Q   (sck_q),
        .i_CS_Q    (cs_q),
        .i_MOSI_Q  (mosi_q),
        .i_RDATA   (rdata),
        .o_MISO    (o_MISO),
        .o_MISO_OE (o_MISO_OE),
        .o_WR_EN   (o_WR_EN),
        .o_RD_EN   (o_RD_EN),
        .o_ADDR    (o_ADDR),
        .o_WDATA   (o_WDATA),
        .o_BUSY    (o_BUSY)
    );

    always #5 clk = ~clk;

    // Model of the upstream synchroniser buffers.
    always @(posedge clk) begin
        sck_q  <= {sck_q[0], sck_raw};
        cs_q   <= {cs_q[0], cs_raw};
        mosi_q <= {mosi_q[0], mosi_raw};
        cyc    <= cyc + 1;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outs_vec();
        return {19'd0, o_MISO, o_MISO_OE, o_WR_EN, o_RD_EN, o_BUSY, o_ADDR, o_WDATA};
    endfunction

    function automatic void push_exp(input logic is_wr, input logic [7:0] a, input logic [31:0] d);
        sb_item_t it;
        it.is_wr = is_wr;
        it.addr  = a;
        it.data  = d;
        sb_q.push_back(it);
    endfunction

    // Strobe monitor: pops the scoreboard and, for reads, presents read
    // data only in the cycle after the strobe.
    always @(negedge clk) begin
        if (sck_q == 2'b01) last_rise = cyc;
        if (o_WR_EN) begin
            wr_count++;
            check_val("wr_expected", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                check_val("wr_kind", 64'(mon_e.is_wr), 64'd1);
                check_val("wr_addr", 64'(o_ADDR), 64'(mon_e.addr));
                check_val("wr_data", 64'(o_WDATA), 64'(mon_e.data));
                check_val("wr_latency", 64'(cyc - last_rise), 64'd1);
            end
            $display("txn WRITE addr=%02h data=%08h cyc=%0d", o_ADDR, o_WDATA, cyc);
        end
        if (o_RD_EN) begin
            rd_count++;
            check_val("rd_expected", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                check_val("rd_kind", 64'(mon_e.is_wr), 64'd0);
                check_val("rd_addr", 64'(o_ADDR), 64'(mon_e.addr));
                check_val("rd_latency", 64'(cyc - last_rise), 64'd1);
                $display("txn READ addr=%02h rdata=%08h cyc=%0d", o_ADDR, mon_e.data, cyc);
                @(posedge clk);
                #1 rdata = mon_e.data;
                @(posedge clk);
                #1 rdata = GARBAGE;
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCK period: MOSI set while low, MISO sampled as SCK rises.
    task automatic spi_bit(input logic b, output logic miso, output logic oe);
        mosi_raw = b;
        wait_cyc(HP);
        miso     = o_MISO;
        oe       = o_MISO_OE;
        sck_raw  = 1'b1;
        wait_cyc(HP);
        sck_raw  = 1'b0;
    endtask

    // Asserts CS and clocks command, address, n_data data bits and n_extra
    // trailing pulses; leaves CS asserted.
    task automatic spi_frame(input logic [7:0] cmd, input logic [7:0] addr,
                             input logic [31:0] wdata, input int n_data, input int n_extra,
                             output logic [31:0] miso_w, output logic [31:0] oe_w,
                             output logic [7:0] oe_cmd);
        logic s, o;
        cs_raw = 1'b0;
        wait_cyc(HP);
        for (int i = 7; i >= 0; i--) begin
            spi_bit(cmd[i], s, o);
            oe_cmd[i] = o;
        end
        for (int i = ADDR_W - 1; i >= 0; i--) spi_bit(addr[i], s, o);
        miso_w = '0;
        oe_w   = '0;
        for (int i = 0; i < n_data; i++) begin
            spi_bit(wdata[DATA_W-1-i], s, o);
            miso_w = {miso_w[30:0], s};
            oe_w   = {oe_w[30:0], o};
        end
        for (int i = 0; i < n_extra; i++) spi_bit(1'b1, s, o);
    endtask

    task automatic cs_release(input int gap);
        mosi_raw = 1'b0;
        cs_raw   = 1'b1;
        wait_cyc(gap);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d limit reached", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] miso_w, oe_w;
        logic [7:0]  oe_c;
        logic [7:0]  cmd;
        logic        s, o;
        int          w0, r0;

        rst_n = 1'b0; sck_raw = 1'b0; cs_raw = 1'b1; mosi_raw = 1'b0; rdata = GARBAGE;
        wait_cyc(3);
        check_val("reset_outputs", outs_vec(), 64'd0);
        rst_n = 1'b1;
        wait_cyc(3);

        // Plain write.
        w0 = wr_count;
        push_exp(1'b1, 8'h5A, 32'hDEADBEEF);
        spi_frame(8'h80, 8'h5A, 32'hDEADBEEF, 32, 0, miso_w, oe_w, oe_c);
        check_val("wr_cmd_oe", 64'(oe_c), 64'd0);
        check_val("wr_data_oe", 64'(oe_w), 64'd0);
        wait_cyc(HP);
        check_val("wr_busy_done", 64'(o_BUSY), 64'd1);
        cs_release(4);
        check_val("wr_count", 64'(wr_count - w0), 64'd1);
        check_val("wr_addr_hold", 64'(o_ADDR), 64'h5A);
        check_val("wr_busy_idle", 64'(o_BUSY), 64'd0);

        // Reset in the middle of a write command.
        w0 = wr_count; r0 = rd_count;
        cmd = 8'h80;
        cs_raw = 1'b0;
        wait_cyc(HP);
        for (int i = 7; i >= 3; i--) spi_bit(cmd[i], s, o);
        rst_n = 1'b0;
        wait_cyc(1);
        check_val("midreset_outputs", outs_vec(), 64'd0);
        wait_cyc(2);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) spi_bit(1'b1, s, o);
        check_val("postreset_busy", 64'(o_BUSY), 64'd0);
        check_val("postreset_strobes", 64'((wr_count - w0) + (rd_count - r0)), 64'd0);
        cs_release(4);

        // Plain read.
        r0 = rd_count;
        push_exp(1'b0, 8'h03, 32'h12345678);
        miso_q.push_back(32'h12345678);
        spi_frame(8'h00, 8'h03, 32'h0, 32, 0, miso_w, oe_w, oe_c);
        check_val("rd_miso", 64'(miso_w), 64'(miso_q.pop_front()));
        check_val("rd_data_oe", 64'(oe_w), 64'hFFFFFFFF);
        check_val("rd_cmd_oe", 64'(oe_c), 64'd0);
        wait_cyc(HP);
        check_val("rd_oe_after", 64'(o_MISO_OE), 64'd0);
        cs_release(4);
        check_val("rd_count", 64'(rd_count - r0), 64'd1);

        // Write aborted after 20 data bits.
        w0 = wr_count;
        spi_frame(8'h80, 8'h22, 32'hFFFF0000, 20, 0, miso_w, oe_w, oe_c);
        cs_release(3);
        check_val("abort_wr_busy", 64'(o_BUSY), 64'd0);
        check_val("abort_wr_count", 64'(wr_count - w0), 64'd0);
        check_val("abort_addr_kept", 64'(o_ADDR), 64'h22);
        wait_cyc(2);
        push_exp(1'b1, 8'h11, 32'h0BADF00D);
        spi_frame(8'h80, 8'h11, 32'h0BADF00D, 32, 0, miso_w, oe_w, oe_c);
        wait_cyc(HP);
        cs_release(4);
        check_val("abort_recover_count", 64'(wr_count - w0), 64'd1);

        // Read aborted mid data phase: MISO drivers must release.
        push_exp(1'b0, 8'h05, 32'hFFFFFFFF);
        spi_frame(8'h00, 8'h05, 32'h0, 10, 0, miso_w, oe_w, oe_c);
        check_val("abort_rd_miso", 64'(miso_w), 64'h3FF);
        check_val("abort_rd_oe_during", 64'(o_MISO_OE), 64'd1);
        cs_release(3);
        check_val("abort_rd_oe", 64'({o_MISO_OE, o_MISO, o_BUSY}), 64'd0);
        wait_cyc(2);

        // Extra SCK pulses after a completed write stay in DONE.
        w0 = wr_count;
        push_exp(1'b1, 8'h44, 32'hA5A55A5A);
        spi_frame(8'h81, 8'h44, 32'hA5A55A5A, 32, 8, miso_w, oe_w, oe_c);
        wait_cyc(HP);
        check_val("extra_busy", 64'(o_BUSY), 64'd1);
        check_val("extra_count", 64'(wr_count - w0), 64'd1);
        cs_release(4);
        check_val("extra_idle", 64'(o_BUSY), 64'd0);

        // Back-to-back read then write with a 2-cycle CS gap.
        w0 = wr_count; r0 = rd_count;
        push_exp(1'b0, 8'h01, 32'h55AA33CC);
        miso_q.push_back(32'h55AA33CC);
        spi_frame(8'h7F, 8'h01, 32'h0, 32, 0, miso_w, oe_w, oe_c);
        check_val("b2b_rd_miso", 64'(miso_w), 64'(miso_q.pop_front()));
        wait_cyc(HP);
        cs_release(2);
        push_exp(1'b1, 8'h01, 32'hCAFEF00D);
        spi_frame(8'h80, 8'h01, 32'hCAFEF00D, 32, 0, miso_w, oe_w, oe_c);
        wait_cyc(HP);
        cs_release(4);
        check_val("b2b_wr_count", 64'(wr_count - w0), 64'd1);
        check_val("b2b_rd_count", 64'(rd_count - r0), 64'd1);

        check_val("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
